// File: rtl/fifo_rr_drain.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain
//
// Consumer stage for a bank of FIFOs. Pops at most one entry per cycle from
// the FIFOs in round-robin order and merges them into a single valid/ready
// stream. A 2-entry skid buffer sits between the FIFO read side and the
// consumer, so fifo_rd_en never depends combinationally on out_ready.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   fifo_dout   packed FIFO heads, slice i belongs to FIFO i
//   fifo_empty  per-FIFO empty flags
//   fifo_rd_en  one-hot (or zero) pop strobe to the FIFOs
//   out_data    head entry of the skid buffer
//   out_src     index of the FIFO the head entry came from
//   out_valid   skid buffer holds at least one entry
//   out_ready   consumer accepts the head when out_valid is also high
//   flush       synchronous clear of buffer, pointer and pop counter
//   pop_count   number of pops since reset/flush, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_rr_drain #(
    parameter int N_FIFOS   = 4,
    parameter int DWIDTH    = 16,
    parameter int IDX_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_FIFOS*DWIDTH-1:0]    fifo_dout,
    input  logic [N_FIFOS-1:0]           fifo_empty,
    output logic [N_FIFOS-1:0]           fifo_rd_en,
    output logic [DWIDTH-1:0]            out_data,
    output logic [IDX_WIDTH-1:0]         out_src,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [15:0]                  pop_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Pointer value that gives FIFO 0 first priority.
    localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(N_FIFOS - 1);

    occ_e                   occ_r, occ_n_s;
    logic [DWIDTH-1:0]      data0_r, data0_n_s;
    logic [DWIDTH-1:0]      data1_r, data1_n_s;
    logic [IDX_WIDTH-1:0]   src0_r, src0_n_s;
    logic [IDX_WIDTH-1:0]   src1_r, src1_n_s;
    logic [IDX_WIDTH-1:0]   last_r, last_n_s;
    logic [15:0]            cnt_r, cnt_n_s;

    logic                   hi_found_s, lo_found_s;
    logic [IDX_WIDTH-1:0]   hi_idx_s, lo_idx_s;
    logic                   grant_valid_s;
    logic [IDX_WIDTH-1:0]   grant_idx_s;
    logic [DWIDTH-1:0]      grant_data_s;
    logic                   pop_s;
    logic                   drain_s;

    // Round-robin search: lowest non-empty index above last wins; otherwise
    // wrap around to the lowest non-empty index at or below last. Scanning
    // downward makes the final assignment the lowest index in each half.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {IDX_WIDTH{1'b0}};
        lo_idx_s   = {IDX_WIDTH{1'b0}};
        for (int i = N_FIFOS - 1; i >= 0; i--) begin
            if (!fifo_empty[i] && (IDX_WIDTH'(i) > last_r)) begin
                hi_found_s = 1'b1;
                hi_idx_s   = IDX_WIDTH'(i);
            end else if (!fifo_empty[i]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = IDX_WIDTH'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        grant_valid_s = hi_found_s | lo_found_s;
        grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Select the granted FIFO's head entry.
    always_comb begin
        grant_data_s = {DWIDTH{1'b0}};
        for (int i = 0; i < N_FIFOS; i++) begin
            grant_data_s = grant_data_s |
                ((grant_idx_s == IDX_WIDTH'(i)) ? fifo_dout[i*DWIDTH +: DWIDTH]
                                                : {DWIDTH{1'b0}});
        end
    end

    // Pop decision uses only occupancy, empties, pointer, flush and reset so
    // out_ready never reaches fifo_rd_en combinationally.
    always_comb begin
        pop_s      = rst && grant_valid_s && (occ_r != OCC_TWO) && !flush;
        drain_s    = out_valid && out_ready;
        fifo_rd_en = {N_FIFOS{1'b0}};
        for (int i = 0; i < N_FIFOS; i++) begin
            fifo_rd_en[i] = pop_s && (grant_idx_s == IDX_WIDTH'(i));
        end
    end

    // Next-state for the skid buffer, arbitration pointer and pop counter.
    always_comb begin
        occ_n_s   = occ_r;
        data0_n_s = data0_r;
        data1_n_s = data1_r;
        src0_n_s  = src0_r;
        src1_n_s  = src1_r;
        last_n_s  = last_r;
        cnt_n_s   = cnt_r;
        if (flush) begin
            // A drain this cycle is still seen by the consumer; its entry is
            // simply dropped together with the rest of the buffer.
            occ_n_s  = OCC_EMPTY;
            last_n_s = LAST_RST;
            cnt_n_s  = 16'd0;
        end else begin
            case ({pop_s, drain_s})
                2'b10: begin
                    last_n_s = grant_idx_s;
                    cnt_n_s  = cnt_r + 16'd1;
                    if (occ_r == OCC_EMPTY) begin
                        data0_n_s = grant_data_s;
                        src0_n_s  = grant_idx_s;
                        occ_n_s   = OCC_ONE;
                    end else begin
                        data1_n_s = grant_data_s;
                        src1_n_s  = grant_idx_s;
                        occ_n_s   = OCC_TWO;
                    end
                end
                2'b01: begin
                    data0_n_s = data1_r;
                    src0_n_s  = src1_r;
                    occ_n_s   = (occ_r == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
                end
                2'b11: begin
                    // Pop requires occ<2 and drain requires occ>0, so this is
                    // only reachable with one entry buffered; the occ=2 arm
                    // is kept for completeness.
                    last_n_s = grant_idx_s;
                    cnt_n_s  = cnt_r + 16'd1;
                    if (occ_r == OCC_TWO) begin
                        data0_n_s = data1_r;
                        src0_n_s  = src1_r;
                        data1_n_s = grant_data_s;
                        src1_n_s  = grant_idx_s;
                    end else begin
                        data0_n_s = grant_data_s;
                        src0_n_s  = grant_idx_s;
                    end
                end
                default: begin
                    occ_n_s = occ_r;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_r   <= OCC_EMPTY;
            data0_r <= {DWIDTH{1'b0}};
            data1_r <= {DWIDTH{1'b0}};
            src0_r  <= {IDX_WIDTH{1'b0}};
            src1_r  <= {IDX_WIDTH{1'b0}};
            last_r  <= LAST_RST;
            cnt_r   <= 16'd0;
        end else begin
            occ_r   <= occ_n_s;
            data0_r <= data0_n_s;
            data1_r <= data1_n_s;
            src0_r  <= src0_n_s;
            src1_r  <= src1_n_s;
            last_r  <= last_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    assign out_valid = (occ_r != OCC_EMPTY);
    assign out_data  = data0_r;
    assign out_src   = src0_r;
    assign pop_count = cnt_r;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_rr_drain. A queue-based FIFO bank feeds the DUT; the
// expected output stream is pushed into a scoreboard queue by the stimulus and
// popped/compared by an independent monitor on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_fifo_rr_drain;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   fifo_dout;
    logic [N-1:0]     fifo_empty;
    logic [N-1:0]     fifo_rd_en;
    logic [N-1:0]     rd_snap;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [15:0]      pop_count;

    logic [15:0]      fq [N][$];
    logic [17:0]      exp_q [$];
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    fifo_rr_drain #(.N_FIFOS(N), .DWIDTH(W), .IDX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .pop_count  (pop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive empty flags and head data from the FIFO model.
    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]       = (fq[i].size() == 0);
            fifo_dout[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : 16'h0000;
        end
    endtask

    task automatic load(input int f, input logic [15:0] d);
        fq[f].push_back(d);
        refresh();
    endtask

    task automatic expect_out(input logic [1:0] s, input logic [15:0] d);
        exp_q.push_back({s, d});
    endtask

    // One clock: sample rd_en mid-cycle, apply FIFO pops just after the edge.
    task automatic cycle();
        @(negedge clk);
        rd_snap = fifo_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_snap[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Scoreboard monitor plus read-strobe sanity on every cycle.
    always @(negedge clk) begin : mon
        logic [17:0] e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got src=%0d data=%0h expected none", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_src", 32'(out_src), 32'(e[17:16]));
                check("out_data", 32'(out_data), 32'(e[15:0]));
            end
        end
        if (fifo_rd_en != 4'b0000) begin
            check("rd_en_onehot", 32'($onehot(fifo_rd_en)), 32'd1);
            check("rd_en_to_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_ready = 1'b1;
        flush     = 1'b0;
        refresh();
        #1 rst = 1'b0;

        // Reset state, then a single entry from FIFO2.
        load(2, 16'h00AB);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_pop_count", 32'(pop_count), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("single_rd_en", 32'(fifo_rd_en), 32'b0100);
        expect_out(2'd2, 16'h00AB);
        cycle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_count", 32'(pop_count), 32'd1);
        cycle();
        check("single_valid_off", 32'(out_valid), 32'd0);
        check("single_count_hold", 32'(pop_count), 32'd1);
        check("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Round-robin fairness: flush resets the pointer so FIFO0 goes first.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_count", 32'(pop_count), 32'd0);
        for (int f = 0; f < N; f++)
            for (int r = 0; r < 3; r++) load(f, 16'(16'h0100 * f + r));
        for (int r = 0; r < 3; r++)
            for (int f = 0; f < N; f++) expect_out(2'(f), 16'(16'h0100 * f + r));
        run(13);
        check("rr_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rr_valid_off", 32'(out_valid), 32'd0);
        check("rr_count", 32'(pop_count), 32'd12);

        // Backpressure: two pops fill the skid buffer, then stall.
        out_ready = 1'b0;
        load(0, 16'h0001);
        load(0, 16'h0002);
        load(0, 16'h0003);
        run(2);
        check("bp_count", 32'(pop_count), 32'd14);
        check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        check("bp_data", 32'(out_data), 32'h0001);
        check("bp_src", 32'(out_src), 32'd0);
        run(2);
        check("bp_count_hold", 32'(pop_count), 32'd14);
        check("bp_data_hold", 32'(out_data), 32'h0001);
        check("bp_valid_hold", 32'(out_valid), 32'd1);
        expect_out(2'd0, 16'h0001);
        expect_out(2'd0, 16'h0002);
        expect_out(2'd0, 16'h0003);
        out_ready = 1'b1;
        run(3);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        check("bp_valid_off", 32'(out_valid), 32'd0);
        check("bp_count_end", 32'(pop_count), 32'd15);

        // Sparse skip with wrap: last=3, only FIFO1 and FIFO3 populated.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        load(1, 16'h00A1);
        load(1, 16'h00A2);
        load(3, 16'h00B1);
        load(3, 16'h00B2);
        #1;
        check("sparse_first_grant", 32'(fifo_rd_en), 32'b0010);
        expect_out(2'd1, 16'h00A1);
        expect_out(2'd3, 16'h00B1);
        expect_out(2'd1, 16'h00A2);
        expect_out(2'd3, 16'h00B2);
        run(5);
        check("sparse_sb_empty", 32'(exp_q.size()), 32'd0);
        check("sparse_count", 32'(pop_count), 32'd4);

        // Flush mid-stream with a full skid buffer.
        out_ready = 1'b0;
        load(1, 16'h0011);
        load(2, 16'h0021);
        load(2, 16'h0022);
        run(2);
        check("fl_full_src", 32'(out_src), 32'd1);
        check("fl_full_count", 32'(pop_count), 32'd6);
        load(0, 16'h0001);
        expect_out(2'd1, 16'h0011);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_rd_en_in_flush", 32'(fifo_rd_en), 32'd0);
        cycle();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("fl_valid_off", 32'(out_valid), 32'd0);
        check("fl_count_zero", 32'(pop_count), 32'd0);
        flush = 1'b1;
        #1;
        check("fl_blocks_pop", 32'(fifo_rd_en), 32'd0);
        flush = 1'b0;
        #1;
        check("fl_next_grant", 32'(fifo_rd_en), 32'b0001);
        expect_out(2'd0, 16'h0001);
        expect_out(2'd2, 16'h0022);
        out_ready = 1'b1;
        run(3);
        check("fl_sb_empty", 32'(exp_q.size()), 32'd0);
        check("fl_count_end", 32'(pop_count), 32'd2);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        load(3, 16'h0031);
        load(3, 16'h0032);
        load(3, 16'h0033);
        run(1);
        check("ar_valid_before", 32'(out_valid), 32'd1);
        check("ar_rd_en_before", 32'(fifo_rd_en), 32'b1000);
        #1 rst = 1'b0;
        #1;
        check("ar_valid_drop", 32'(out_valid), 32'd0);
        check("ar_rd_en_drop", 32'(fifo_rd_en), 32'd0);
        check("ar_count_drop", 32'(pop_count), 32'd0);
        check("ar_data_drop", 32'(out_data), 32'd0);
        cycle();
        check("ar_rd_en_held", 32'(fifo_rd_en), 32'd0);
        rst = 1'b1;
        load(0, 16'h00F0);
        #1;
        check("ar_first_grant", 32'(fifo_rd_en), 32'b0001);
        expect_out(2'd0, 16'h00F0);
        expect_out(2'd3, 16'h0032);
        expect_out(2'd3, 16'h0033);
        out_ready = 1'b1;
        run(4);
        check("ar_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ar_count", 32'(pop_count), 32'd3);
        check("ar_valid_off", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
